// File: rtl/letter_pkg.sv
`default_nettype none
// ============================================================================
// Module : letter_pkg
// Brief  : Shared definitions for the 2-bit letter symbol link transmitter.
//          This package holds the symbol constants, the letter_sel encodings,
//          the FSM state type, and the letter-to-halves decode function.
// Rev    : 1.0  initial release
// ============================================================================
package letter_pkg;

  // Symbol values as {MSB, LSB}
  localparam logic [1:0] SYM_E_FIRST  = 2'b11;
  localparam logic [1:0] SYM_E_SECOND = 2'b10;
  localparam logic [1:0] SYM_C_FIRST  = 2'b11;
  localparam logic [1:0] SYM_C_SECOND = 2'b00;
  localparam logic [1:0] SYM_IDLE     = 2'b00;

  // letter_sel encodings
  localparam logic [1:0] SEL_E    = 2'b00;
  localparam logic [1:0] SEL_C    = 2'b01;
  localparam logic [1:0] SEL_IDLE = 2'b10;
  localparam logic [1:0] SEL_RAW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FIRST  = 2'b01,
    ST_SECOND = 2'b10,
    ST_GAP    = 2'b11
  } tx_state_t;

  // Returns {first_half, second_half} for a stored request.
  function automatic logic [3:0] letter_halves(input logic [1:0] sel,
                                               input logic [3:0] raw);
    logic [3:0] halves;
    case (sel)
      SEL_E:    halves = {SYM_E_FIRST, SYM_E_SECOND};
      SEL_C:    halves = {SYM_C_FIRST, SYM_C_SECOND};
      SEL_IDLE: halves = {SYM_IDLE, SYM_IDLE};
      default:  halves = raw;
    endcase
    return halves;
  endfunction

endpackage
`default_nettype wire

// File: rtl/letter_fifo.sv
`default_nettype none
// ============================================================================
// Module : letter_fifo
// Brief  : DEPTH x 6-bit synchronous request FIFO. The read data shows the
//          head entry combinationally. This FIFO has no push/pop bypass: when
//          the FIFO is full, a push is refused even if a pop happens in the
//          same cycle.
// Ports  : clk, rst_n (async active-low)
//          push/wr_data   - write request; ignored while full
//          pop            - remove head; ignored while empty
//          rd_data        - head entry
//          full/empty/count - occupancy status
// Rev    : 1.0  initial release
// ============================================================================
module letter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [5:0]                     wr_data,
  input  logic                           pop,
  output logic [5:0]                     rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  logic [5:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full      = (r_count == c_DEPTH);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rd_data   = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/letter_symbol_tx.sv
`default_nettype none
// ============================================================================
// Module : letter_symbol_tx
// Brief  : Transmit side of the 2-bit letter symbol link. This module takes
//          queued letter requests and emits each one as a two-symbol sequence.
//          After each letter it can insert GAP_CYCLES idle (00) symbols.
// Ports  : clk, rst_n (async active-low)
//          in_valid/in_ready       - request write handshake (ready = !full)
//          letter_sel, raw_sym     - request payload, captured at push
//          sym_msb/sym_lsb         - registered symbol outputs
//          letter_done             - high while the second half is driven
//          busy                    - FSM active or requests pending
//          fifo_count              - stored requests
// Config : LETTER_TX_HOLD2_EN - when defined, each symbol is held for two
//          clocks. When undefined, each symbol lasts one clock.
// Rev    : 1.0  initial release
// ============================================================================
module letter_symbol_tx
  import letter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     letter_sel,
  input  logic [3:0]                     raw_sym,
  output logic                           sym_msb,
  output logic                           sym_lsb,
  output logic                           letter_done,
  output logic                           busy,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] c_GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t     r_state;
  tx_state_t     w_state_next;
  logic [3:0]    r_halves;
  logic [GW-1:0] r_gap_cnt;
  logic [1:0]    w_sym_next;
  logic          w_pop;
  logic          w_tick;
  logic          w_full;
  logic          w_empty;
  logic [5:0]    w_head;
  logic [3:0]    w_head_halves;

  letter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .wr_data ({letter_sel, raw_sym}),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  assign in_ready      = !w_full;
  assign busy          = (r_state != ST_IDLE) || !w_empty;
  assign w_head_halves = letter_halves(w_head[5:4], w_head[3:0]);

`ifdef LETTER_TX_HOLD2_EN
  // r_hold marks the second clock of a symbol period. It restarts on leaving
  // IDLE so that the first half is aligned to the pop edge.
  logic r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_hold <= 1'b0;
    end else begin
      r_hold <= ~r_hold;
    end
  end

  assign w_tick = r_hold;
`else
  assign w_tick = 1'b1;
`endif

  // Next-state logic. A pop happens only at a symbol-period boundary, except
  // in IDLE: there a pop happens as soon as a request is waiting.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (w_tick) w_state_next = ST_SECOND;
      end
      ST_SECOND: begin
        if (w_tick) begin
          if (GAP_CYCLES > 0) begin
            w_state_next = ST_GAP;
          end else if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_FIRST;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (w_tick && (r_gap_cnt == c_GAP_LAST)) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_FIRST;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The output symbol follows the state being entered. A freshly popped
  // letter supplies its first half directly from the FIFO head.
  always_comb begin
    w_sym_next = SYM_IDLE;
    case (w_state_next)
      ST_FIRST:  w_sym_next = w_pop ? w_head_halves[3:2] : r_halves[3:2];
      ST_SECOND: w_sym_next = r_halves[1:0];
      default:   w_sym_next = SYM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_halves    <= '0;
      r_gap_cnt   <= '0;
      sym_msb     <= 1'b0;
      sym_lsb     <= 1'b0;
      letter_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) r_halves <= w_head_halves;
      if (r_state != ST_GAP) begin
        r_gap_cnt <= '0;
      end else if (w_tick) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
      {sym_msb, sym_lsb} <= w_sym_next;
      letter_done        <= (w_state_next == ST_SECOND);
    end
  end

endmodule
`default_nettype wire
